debug_fifo: RTL and testbench
=============================

DEBUG_FIFO -- requirements
Module: debug_fifo

Interface
REQ-001 The block SHALL have parameter B, default 8, meaning the data word width in bits.
REQ-002 The block SHALL have parameter W, default 8, meaning the address width, so depth = 2^W words.
REQ-003 The block SHALL have parameter AF_LEVEL, default 2^W-4, meaning the almost_full threshold in words.
REQ-004 The block SHALL have parameter AE_LEVEL, default 4, meaning the almost_empty threshold in words.
REQ-005 The block SHALL have parameter SNAP_WORDS, default 4, meaning the number of B-bit words in one snapshot.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have ports wr and rd, input, 1 bit each: push and pop requests.
REQ-009 The block SHALL have port w_data, input, B bits: push data.
REQ-010 The block SHALL have port r_data, output, B bits: head word (first-word-fall-through).
REQ-011 The block SHALL have ports full, empty, almost_full and almost_empty, output, 1 bit each: status flags.
REQ-012 The block SHALL have port count, output, W+1 bits: current occupancy.
REQ-013 The block SHALL have ports overflow and underflow, output, 1 bit each: sticky error flags.
REQ-014 The block SHALL have port clr_err, input, 1 bit: synchronous clear for both sticky error flags.
REQ-015 The block SHALL have port snap_req, input, 1 bit: one-cycle request to capture a snapshot.
REQ-016 The block SHALL have port snap_data, input, SNAP_WORDS*B bits: snapshot source, e.g. a debug register.
REQ-017 The block SHALL have port snap_busy, output, 1 bit: high while snapshot words are being loaded.

Function
REQ-018 A push SHALL occur when wr=1 and full=0, writing to the word at w_ptr, with w_ptr then incrementing modulo 2^W.
REQ-019 A pop SHALL occur when rd=1 and empty=0, with r_ptr then incrementing modulo 2^W.
REQ-020 r_data SHALL equal mem[r_ptr] combinationally, with zero read latency; its value is don't-care while empty=1.
REQ-021 A simultaneous wr and rd SHALL behave as follows, with the flags evaluated from the pre-edge state:
- Not empty and not full: push and pop both occur; count is unchanged.
- Empty: push only.
- Full: pop only.
REQ-022 Flag definitions, all registered or derived from registered count:
- empty: count==0.
- full: count==2^W.
- almost_full: count>=AF_LEVEL.
- almost_empty: count<=AE_LEVEL.
REQ-023 Error flags:
- overflow SHALL set on any cycle with wr=1 and full=1.
- underflow SHALL set on any cycle with rd=1 and empty=1.
- Both SHALL remain set until clr_err=1 or reset.
- If set and clear coincide, clear SHALL win.
REQ-024 The snapshot FSM SHALL have states IDLE and LOAD.
REQ-025 In IDLE, snap_req=1 SHALL latch snap_data into a holding register, set the word index to 0 and move to LOAD.
REQ-026 In LOAD, each cycle with full=0 SHALL push holding word index i, most-significant word first (bits [SNAP_WORDS*B-1 -: B] at i=0), then increment i.
REQ-027 LOAD SHALL stall without pushing while full=1, and this SHALL NOT set overflow.
REQ-028 LOAD SHALL return to IDLE in the cycle after the push of word SNAP_WORDS-1.
REQ-029 In LOAD, external wr SHALL be ignored and SHALL set overflow.
REQ-030 In LOAD, rd SHALL operate normally, so a pop and a snapshot push may coincide.
REQ-031 snap_req SHALL be ignored while snap_busy=1.
REQ-032 snap_busy SHALL be 1 exactly while the FSM is in LOAD.

Reset
REQ-033 reset_n=0 SHALL asynchronously force the following reset values:
- w_ptr=0, r_ptr=0, count=0.
- empty=1, full=0, almost_empty=1, almost_full=0.
- overflow=0, underflow=0.
- FSM=IDLE, snap_busy=0.
REQ-034 Memory contents SHALL NOT be reset.
REQ-035 Reset asserted mid-LOAD SHALL abandon the snapshot, and no further snapshot words SHALL be pushed.

Structure
REQ-036 A shared package debug_pkg SHALL hold the FSM state typedef (IDLE, LOAD) and the default parameter constants.
REQ-037 The storage array SHALL be a sub-module fifo_ram: one write port, one asynchronous read port, no reset.

Verification
REQ-038 B=8, W=2: push 0x11, 0x22, 0x33, 0x44 -> full=1 and count=4; then a fifth wr -> overflow=1 and the FIFO is unchanged.
REQ-039 Pop 4 times -> r_data sequence 0x11, 0x22, 0x33, 0x44, then empty=1; a fifth rd -> underflow=1; clr_err -> both error flags 0.
REQ-040 With count=2, wr+rd for 10 cycles across the pointer wrap -> count stays 2 and the data order is preserved.
REQ-041 snap_req with snap_data=0xDEADBEEF on an empty FIFO (W=4) -> snap_busy for 4 cycles, then pops return 0xDE, 0xAD, 0xBE, 0xEF.
REQ-042 W=2 with count=3 at snap_req -> one word pushed, then a stall; after 3 pops the remaining words load, overflow stays 0, snap_busy drops after the last word.
REQ-043 reset_n pulsed low during LOAD after 2 words -> immediately count=0, empty=1, snap_busy=0, and no later pushes occur.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types and default parameter constants for the debug FIFO slice.
package debug_pkg;

  localparam int DEF_B          = 8;
  localparam int DEF_W          = 8;
  localparam int DEF_AE_LEVEL   = 4;
  localparam int DEF_SNAP_WORDS = 4;

  // The default almost_full threshold sits four words below the top of the FIFO.
  function automatic int def_af_level(input int w);
    return (1 << w) - 4;
  endfunction

  // Snapshot loader states: IDLE waits for a request, LOAD pushes the held words.
  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } snap_state_e;

endpackage

// File: rtl/debug_fifo_if.sv
// Bus bundle for debug_fifo: push/pop handshake, status, error and snapshot signals.
interface debug_fifo_if
  import debug_pkg::*;
#(
  parameter int B          = DEF_B,
  parameter int W          = DEF_W,
  parameter int SNAP_WORDS = DEF_SNAP_WORDS
) ();

  // Push / pop handshake
  logic                  wr;
  logic                  rd;
  logic [B-1:0]          w_data;
  logic [B-1:0]          r_data;

  // Occupancy and status
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [W:0]            count;

  // Sticky error flags and their clear
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;

  // Snapshot capture
  logic                  snap_req;
  logic [SNAP_WORDS*B-1:0] snap_data;
  logic                  snap_busy;

  // FIFO side.
  modport slave (
    input  wr, rd, w_data, clr_err, snap_req, snap_data,
    output r_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow, snap_busy
  );

  // Producer / consumer side.
  modport master (
    output wr, rd, w_data, clr_err, snap_req, snap_data,
    input  r_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow, snap_busy
  );

endinterface

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module fifo_ram
  import debug_pkg::*;
#(
  parameter int B = DEF_B,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic [B-1:0] wdata,
  input  logic [W-1:0] raddr,
  output logic [B-1:0] rdata
);

  logic [B-1:0] mem [2**W];

  // Write the addressed word on a push.
  // NOTE: the array is deliberately left out of reset so it maps onto plain RAM;
  // stale words are never visible because the pointers and count are reset.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Head word is available in the same cycle (first-word-fall-through).
  assign rdata = mem[raddr];

endmodule

// File: rtl/debug_fifo.sv
// Debug FIFO: FWFT FIFO with status flags, sticky error flags and a snapshot
// loader that pushes a multi-word debug register into the FIFO, MSW first.
module debug_fifo
  import debug_pkg::*;
#(
  parameter int B          = DEF_B,
  parameter int W          = DEF_W,
  parameter int AF_LEVEL   = def_af_level(W),
  parameter int AE_LEVEL   = DEF_AE_LEVEL,
  parameter int SNAP_WORDS = DEF_SNAP_WORDS
) (
  input logic         clk,
  input logic         reset_n,
  debug_fifo_if.slave bus
);

  localparam int SNAP_BITS = SNAP_WORDS * B;
  localparam int IDX_W     = (SNAP_WORDS > 1) ? $clog2(SNAP_WORDS) : 1;

  localparam logic [W:0]       DEPTH_C  = (W+1)'(1 << W);
  localparam logic [W:0]       AF_C     = (W+1)'(AF_LEVEL);
  localparam logic [W:0]       AE_C     = (W+1)'(AE_LEVEL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SNAP_WORDS - 1);

  // Snapshot loader
  snap_state_e          state_q;
  snap_state_e          state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [SNAP_BITS-1:0] hold_q;
  logic                 loading;
  logic                 snap_load;
  logic                 snap_push;
  logic [B-1:0]         snap_word;

  // FIFO core
  logic [W-1:0]         w_ptr_q;
  logic [W-1:0]         r_ptr_q;
  logic [W:0]           count_q;
  logic                 full;
  logic                 empty;
  logic                 push_req;
  logic [B-1:0]         push_data;
  logic                 do_push;
  logic                 do_pop;

  // Sticky errors
  logic                 ovf_q;
  logic                 unf_q;
  logic                 ovf_set;
  logic                 unf_set;

  // ---------------------------------------------------------------------------
  // Snapshot FSM
  // ---------------------------------------------------------------------------

  // State register; reset abandons any snapshot in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enter LOAD on a request, leave it with the push of the last word.
  always_comb begin
    // NOTE: state_d gets a default before the case so no path leaves it unassigned.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.snap_req) state_d = LOAD;
      LOAD:    if (!full && (idx_q == LAST_IDX)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: capture strobe in IDLE, push strobe in LOAD whenever there is room.
  always_comb begin
    snap_load     = 1'b0;
    snap_push     = 1'b0;
    bus.snap_busy = 1'b0;
    unique case (state_q)
      IDLE: snap_load = bus.snap_req;
      LOAD: begin
        snap_push     = !full;
        bus.snap_busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign loading = (state_q == LOAD);

  // Holding register: latch the source on capture, then shift left one word per
  // push so the word for index idx_q always sits in the top B bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      idx_q  <= '0;
    end else if (snap_load) begin
      hold_q <= bus.snap_data;
      idx_q  <= '0;
    end else if (snap_push) begin
      hold_q <= hold_q << B;
      idx_q  <= idx_q + IDX_W'(1);
    end
  end

  assign snap_word = hold_q[SNAP_BITS-1 -: B];

  // ---------------------------------------------------------------------------
  // FIFO core
  // ---------------------------------------------------------------------------

  // While loading, the snapshot owns the write side and external wr is dropped.
  assign push_req  = loading ? snap_push : bus.wr;
  assign push_data = loading ? snap_word : bus.w_data;
  assign do_push   = push_req && !full;
  assign do_pop    = bus.rd && !empty;

  // Flags are decoded from the registered count.
  assign empty            = (count_q == '0);
  assign full             = (count_q == DEPTH_C);
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;

  // Pointers wrap naturally at 2^W; count tracks push minus pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) w_ptr_q <= w_ptr_q + W'(1);
      if (do_pop)  r_ptr_q <= r_ptr_q + W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (W+1)'(1);
        2'b01:   count_q <= count_q - (W+1)'(1);
        default: ;
      endcase
    end
  end

  fifo_ram #(
    .B (B),
    .W (W)
  ) u_ram (
    .clk   (clk),
    .we    (do_push),
    .waddr (w_ptr_q),
    .wdata (push_data),
    .raddr (r_ptr_q),
    .rdata (bus.r_data)
  );

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------

  // A stalled snapshot never counts as overflow; only external wr does.
  assign ovf_set = bus.wr && (full || loading);
  assign unf_set = bus.rd && empty;

  // Set on error, hold until cleared; a clear in the same cycle as a set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.clr_err) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_debug_fifo.sv
// Testbench for debug_fifo: two instances (W=2 and W=4) checked every cycle
// against a queue-based reference, plus directed literal checks.
module tb_debug_fifo;

  logic clk = 1'b0;
  logic reset_n;

  logic        wr_s   [2];
  logic        rd_s   [2];
  logic [7:0]  wd_s   [2];
  logic        clr_s  [2];
  logic        snap_s [2];
  logic [31:0] sd_s   [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Lane 0: W=2, AF=3, AE=1.  Lane 1: W=4 with default-style thresholds.
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LW    = (g == 0) ? 2 : 4;
    localparam int DEPTH = 1 << LW;
    localparam int AF    = (g == 0) ? 3 : DEPTH - 4;
    localparam int AE    = (g == 0) ? 1 : 4;

    debug_fifo_if #(.B(8), .W(LW), .SNAP_WORDS(4)) bus ();

    debug_fifo #(
      .B          (8),
      .W          (LW),
      .AF_LEVEL   (AF),
      .AE_LEVEL   (AE),
      .SNAP_WORDS (4)
    ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
    );

    assign bus.wr        = wr_s[g];
    assign bus.rd        = rd_s[g];
    assign bus.w_data    = wd_s[g];
    assign bus.clr_err   = clr_s[g];
    assign bus.snap_req  = snap_s[g];
    assign bus.snap_data = sd_s[g];

    logic [7:0] mq   [$];
    logic [7:0] pend [$];
    bit         m_ovf;
    bit         m_unf;

    // Reference: FIFO contents as a queue, outstanding snapshot words as another.
    always @(posedge clk or negedge reset_n) begin : model
      int          n;
      bit          busy;
      bit          m_full;
      bit          m_empty;
      logic [31:0] sd;
      if (!reset_n) begin
        mq.delete();
        pend.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else begin
        n       = mq.size();
        busy    = (pend.size() != 0);
        m_full  = (n == DEPTH);
        m_empty = (n == 0);
        if (bus.clr_err) begin
          m_ovf = 1'b0;
          m_unf = 1'b0;
        end else begin
          if (bus.wr && (m_full || busy)) m_ovf = 1'b1;
          if (bus.rd && m_empty)          m_unf = 1'b1;
        end
        if (bus.rd && !m_empty) void'(mq.pop_front());
        if (!m_full) begin
          if (busy)        mq.push_back(pend.pop_front());
          else if (bus.wr) mq.push_back(bus.w_data);
        end
        if (!busy && bus.snap_req) begin
          sd = bus.snap_data;
          pend.push_back(sd[31:24]);
          pend.push_back(sd[23:16]);
          pend.push_back(sd[15:8]);
          pend.push_back(sd[7:0]);
        end
      end
    end

    // Compare every DUT output against the reference away from the active edge.
    always @(negedge clk) begin : compare
      int n;
      if (reset_n) begin
        n = mq.size();
        check($sformatf("lane%0d count", g),        32'(bus.count),        32'(n));
        check($sformatf("lane%0d empty", g),        32'(bus.empty),        32'(n == 0));
        check($sformatf("lane%0d full", g),         32'(bus.full),         32'(n == DEPTH));
        check($sformatf("lane%0d almost_full", g),  32'(bus.almost_full),  32'(n >= AF));
        check($sformatf("lane%0d almost_empty", g), 32'(bus.almost_empty), 32'(n <= AE));
        check($sformatf("lane%0d overflow", g),     32'(bus.overflow),     32'(m_ovf));
        check($sformatf("lane%0d underflow", g),    32'(bus.underflow),    32'(m_unf));
        check($sformatf("lane%0d snap_busy", g),    32'(bus.snap_busy),    32'(pend.size() != 0));
        if (n != 0) check($sformatf("lane%0d r_data", g), 32'(bus.r_data), 32'(mq[0]));
      end
    end
  end

  // One cycle of stimulus: drive at the falling edge, return at the next one.
  task automatic drive(input int id, input bit w, input bit r, input logic [7:0] d,
                       input bit c, input bit s, input logic [31:0] sd);
    wr_s[id]   = w;
    rd_s[id]   = r;
    wd_s[id]   = d;
    clr_s[id]  = c;
    snap_s[id] = s;
    sd_s[id]   = sd;
    @(negedge clk);
  endtask

  task automatic idle(input int id);
    drive(id, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic push(input int id, input logic [7:0] d);
    drive(id, 1'b1, 1'b0, d, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic pop(input int id);
    drive(id, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 32'h0);
  endtask

  function automatic logic [7:0] rdata_of(input int id);
    return (id == 0) ? lane[0].bus.r_data : lane[1].bus.r_data;
  endfunction

  // Check the head word against a literal, then pop it.
  task automatic pop_expect(input int id, input logic [7:0] e, input string name);
    check(name, 32'(rdata_of(id)), 32'(e));
    pop(id);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] exp4 [4];
    int         busy_cycles;

    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_s[i] = 1'b0; rd_s[i] = 1'b0; wd_s[i] = 8'h00;
      clr_s[i] = 1'b0; snap_s[i] = 1'b0; sd_s[i] = 32'h0;
    end
    repeat (2) @(negedge clk);

    // Reset values
    check("rst count",        32'(lane[0].bus.count),        0);
    check("rst empty",        32'(lane[0].bus.empty),        1);
    check("rst full",         32'(lane[0].bus.full),         0);
    check("rst almost_empty", 32'(lane[0].bus.almost_empty), 1);
    check("rst almost_full",  32'(lane[0].bus.almost_full),  0);
    check("rst overflow",     32'(lane[0].bus.overflow),     0);
    check("rst underflow",    32'(lane[0].bus.underflow),    0);
    check("rst snap_busy",    32'(lane[0].bus.snap_busy),    0);
    check("rst b count",      32'(lane[1].bus.count),        0);
    reset_n = 1'b1;
    @(negedge clk);

    // Fill lane 0 to full, then one push too many.
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44);
    check("fill full",         32'(lane[0].bus.full),         1);
    check("fill count",        32'(lane[0].bus.count),        4);
    check("fill almost_full",  32'(lane[0].bus.almost_full),  1);
    check("fill almost_empty", 32'(lane[0].bus.almost_empty), 0);
    push(0, 8'h55);
    check("ovf set",        32'(lane[0].bus.overflow), 1);
    check("ovf count kept", 32'(lane[0].bus.count),    4);
    check("ovf head kept",  32'(lane[0].bus.r_data),   32'h11);
    idle(0);

    // Drain in order, one pop too many, then clear (clear beats a same-cycle set).
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) pop_expect(0, exp4[i], "drain data");
    check("drain empty", 32'(lane[0].bus.empty), 1);
    pop(0);
    check("unf set",    32'(lane[0].bus.underflow), 1);
    check("ovf sticky", 32'(lane[0].bus.overflow),  1);
    drive(0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0);
    check("clr ovf", 32'(lane[0].bus.overflow),  0);
    check("clr unf", 32'(lane[0].bus.underflow), 0);
    idle(0);

    // Steady wr+rd at count 2 across several pointer wraps.
    push(0, 8'hA0); push(0, 8'hA1);
    for (int i = 0; i < 10; i++) begin
      check("wrap head", 32'(lane[0].bus.r_data), 32'(8'hA0 + i));
      drive(0, 1'b1, 1'b1, 8'(8'hA2 + i), 1'b0, 1'b0, 32'h0);
      check("wrap count", 32'(lane[0].bus.count), 2);
    end
    pop_expect(0, 8'hAA, "wrap tail");
    pop_expect(0, 8'hAB, "wrap tail");

    // wr+rd on empty pushes only; wr+rd on full pops only.
    drive(0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 32'h0);
    check("wr+rd empty count", 32'(lane[0].bus.count),     1);
    check("wr+rd empty head",  32'(lane[0].bus.r_data),    32'h77);
    check("wr+rd empty unf",   32'(lane[0].bus.underflow), 1);
    push(0, 8'h78); push(0, 8'h79); push(0, 8'h7A);
    drive(0, 1'b1, 1'b1, 8'h7B, 1'b0, 1'b0, 32'h0);
    check("wr+rd full count", 32'(lane[0].bus.count),    3);
    check("wr+rd full head",  32'(lane[0].bus.r_data),   32'h78);
    check("wr+rd full ovf",   32'(lane[0].bus.overflow), 1);
    drive(0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
    pop(0); pop(0); pop(0);
    idle(0);

    // Snapshot into a W=2 FIFO holding 3 words: one push, stall, finish after pops.
    push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
    drive(0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'hCAFEF00D);
    check("stall busy0", 32'(lane[0].bus.snap_busy), 1);
    check("stall cnt0",  32'(lane[0].bus.count),     3);
    idle(0);
    check("stall cnt1",  32'(lane[0].bus.count),     4);
    idle(0);
    check("stall cnt2",  32'(lane[0].bus.count),     4);
    check("stall busy2", 32'(lane[0].bus.snap_busy), 1);
    pop_expect(0, 8'h01, "stall pop");
    pop_expect(0, 8'h02, "stall pop");
    pop_expect(0, 8'h03, "stall pop");
    check("stall busy3", 32'(lane[0].bus.snap_busy), 1);
    idle(0);
    check("stall done busy", 32'(lane[0].bus.snap_busy), 0);
    check("stall done cnt",  32'(lane[0].bus.count),     4);
    check("stall no ovf",    32'(lane[0].bus.overflow),  0);
    exp4 = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    for (int i = 0; i < 4; i++) pop_expect(0, exp4[i], "stall data");
    idle(0);

    // Snapshot into an empty W=4 FIFO: busy for exactly 4 cycles, MSW first.
    drive(1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'hDEADBEEF);
    busy_cycles = 0;
    for (int k = 0; k < 16 && lane[1].bus.snap_busy; k++) begin
      busy_cycles++;
      idle(1);
    end
    check("snap busy cycles", 32'(busy_cycles),          4);
    check("snap busy low",    32'(lane[1].bus.snap_busy), 0);
    check("snap count",       32'(lane[1].bus.count),     4);
    exp4 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < 4; i++) pop_expect(1, exp4[i], "snap data");
    idle(1);

    // External wr during LOAD is dropped and flags overflow; snap_req is ignored.
    drive(1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'h11223344);
    drive(1, 1'b1, 1'b0, 8'h99, 1'b0, 1'b1, 32'h55667788);
    check("load wr ovf",   32'(lane[1].bus.overflow), 1);
    check("load wr count", 32'(lane[1].bus.count),    1);
    for (int k = 0; k < 16 && lane[1].bus.snap_busy; k++) idle(1);
    check("load end busy",  32'(lane[1].bus.snap_busy), 0);
    check("load end count", 32'(lane[1].bus.count),     4);
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) pop_expect(1, exp4[i], "load data");
    check("load drained", 32'(lane[1].bus.empty), 1);
    drive(1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
    idle(1);

    // Reset in the middle of LOAD after two words.
    drive(1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 32'hA1B2C3D4);
    idle(1);
    idle(1);
    check("mid count", 32'(lane[1].bus.count),     2);
    check("mid busy",  32'(lane[1].bus.snap_busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async rst count", 32'(lane[1].bus.count),        0);
    check("async rst empty", 32'(lane[1].bus.empty),        1);
    check("async rst busy",  32'(lane[1].bus.snap_busy),    0);
    check("async rst ae",    32'(lane[1].bus.almost_empty), 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) idle(1);
    check("post rst count", 32'(lane[1].bus.count),     0);
    check("post rst empty", 32'(lane[1].bus.empty),     1);
    check("post rst busy",  32'(lane[1].bus.snap_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
